fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Sequencing controller for the 64-point radix-2 FFT engine. It owns one dual-port sample RAM and the combinational `fft_core2` butterfly, and runs a full transform in three phases: load 64 input samples, issue all 192 in-place DIT butterflies stage by stage with twiddle indices, then stream out 64 results. The controller carries only addresses and strobes; sample data moves on the RAM/butterfly datapath, which is built outside this block.

## Interface
Parameters:
- `RD_LAT`, 1: sample RAM read latency in cycles (1..3).
- `BF_LAT`, 0: butterfly pipeline depth in cycles (0..3).

Ports:
- `clk` input 1: clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start_i` input 1: begin a transform; sampled only in IDLE.
- `busy_o` output 1: high in every state except IDLE.
- `done_o` output 1: one-cycle pulse at end of UNLOAD.
- `din_valid_i` input 1: input sample present on RAM write data.
- `din_ready_o` output 1: high in LOAD.
- `ld_wr_en_o` output 1: load write strobe, `din_valid_i & din_ready_o`.
- `ld_wr_addr_o` output 6: load write address.
- `rd_en_o` output 1: butterfly/unload read strobe.
- `rd_addr_a_o` output 6: read address for port A.
- `rd_addr_b_o` output 6: read address for port B.
- `tw_idx_o` output 5: twiddle ROM index k for W64^k, aligned with `bf_valid_o`.
- `bf_valid_o` output 1: butterfly inputs valid this cycle.
- `wr_en_o` output 1: butterfly result writeback strobe.
- `wr_addr_a_o` output 6: writeback address for port A.
- `wr_addr_b_o` output 6: writeback address for port B.
- `stage_o` output 3: current stage, 0..5.
- `dout_valid_o` output 1: result on RAM port A read data.
- `dout_last_o` output 1: marks result 63.

## Operation
State machine: IDLE, LOAD, CALC, DRAIN, UNLOAD, DONE.

- **IDLE**
  - Go to LOAD on `start_i`.
- **LOAD**
  - Sample counter n runs 0..63 and advances only on `ld_wr_en_o`.
  - `ld_wr_addr_o` = bitrev6(n) (see Configuration).
  - After n = 63 is accepted, clear the butterfly counter and stage, then go to CALC.
- **CALC**
  - Butterfly counter k runs 0..31, one per cycle, with `rd_en_o` = 1 and s = `stage_o`.
  - span = 1<<s.
  - `rd_addr_a_o` = ((k>>s)<<(s+1)) | (k & (span−1)).
  - `rd_addr_b_o` = `rd_addr_a_o` + span.
  - twiddle = (k & (span−1)) << (5−s).
  - After k = 31, go to DRAIN.
- **DRAIN**
  - Lasts D = RD_LAT+BF_LAT cycles. This stops stage s+1 from reading locations not yet written by stage s.
  - When D = 0, DRAIN is skipped.
  - At the end of DRAIN: if s < 5, increment s, clear k, and go to CALC; otherwise go to UNLOAD.
- **UNLOAD**
  - Issue reads of addresses 0..63 in natural order, one per cycle, on port A.
  - After the read of address 63 is issued, wait RD_LAT cycles, then go to DONE.
- **DONE**
  - `done_o` = 1 for one cycle, then IDLE.

Pipeline alignment:
- Twiddle index and each issued address are delayed through shift registers.
- `bf_valid_o` and `tw_idx_o` lag `rd_en_o` by RD_LAT.
- `wr_en_o` and `wr_addr_*` lag by RD_LAT+BF_LAT.
- `dout_valid_o` lags an UNLOAD read by RD_LAT; `dout_last_o` goes with address 63.
- `rd_en_o` during UNLOAD drives neither `bf_valid_o` nor `wr_en_o`; a phase tag travels down the delay line to separate the two.

Boundary and error cases:
- `start_i` outside IDLE is ignored.
- `din_valid_i` outside LOAD is ignored.
- No input backpressure beyond `din_ready_o`.
- No output backpressure: the result sink must accept every `dout_valid_o`.
- `rst_n` low at any point: on the next edge, state becomes IDLE, all counters and delay lines clear, and partial results are discarded.

## Timing
- Reset value of every output is 0, including `din_ready_o`, addresses and `stage_o`.
- `start_i` high at edge t → LOAD from t+1, with `busy_o` and `din_ready_o` high.
- CALC+DRAIN span exactly 6·(32+D) cycles.
- UNLOAD spans 64+RD_LAT cycles; DONE spans 1 cycle.
- Last writeback `wr_en_o` falls in the final DRAIN cycle.
- Minimum transform time with continuous input and defaults (D = 1) is 64 + 198 + 65 + 1 = 328 cycles from LOAD entry.
- A new `start_i` is accepted the cycle after DONE.

## Configuration
Macro `FFT_CTRL_BITREV_LOAD_EN`:
- Defined: `ld_wr_addr_o` = bit-reversed n, so input arrives in natural order.
- Undefined: `ld_wr_addr_o` = n, so upstream delivers samples already in bit-reversed order.
- CALC and UNLOAD behave the same either way.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with `start_i`=1 → all outputs 0; state IDLE.
2. **Load with gaps, macro defined:** drive `din_valid_i` 1,0,1,1 → `ld_wr_addr_o` sequence 0, 32, 16; LOAD exits only after 64 accepts.
3. **Stage 0 (defaults):** k = 0,1,2 → addresses (0,1), (2,3), (4,6) are wrong; required A/B = (0,1), (2,3), (4,5). Twiddle 0 always. `wr_addr` pairs lag `rd` pairs by 1 cycle.
4. **Stage 5:** k = 3 → A=3, B=35, `tw_idx_o`=3. Stage 2, k = 5 → A=9, B=13, twiddle=8.
5. **Full run (defaults, continuous input):**
   - 198 cycles from CALC entry to UNLOAD.
   - 64 `dout_valid_o` pulses with `dout_last_o` on the last.
   - `done_o` a single pulse.
   - Repeat with RD_LAT=2, BF_LAT=1 → 210 CALC/DRAIN cycles.
6. **Robustness:**
   - `start_i` pulsed mid-CALC → ignored.
   - `rst_n` low at stage 3, k=10 → IDLE with outputs 0 next cycle.
   - A fresh run afterwards completes normally.

Source files
------------

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - address/strobe sequencer for the 64-point radix-2 DIT FFT engine
// Optional feature: define FFT_CTRL_BITREV_LOAD_EN to bit-reverse load addresses
// so that samples can arrive in natural order; otherwise samples arrive pre-reversed.
// Ports:
//   clk, rst_n                              clock, synchronous active-low reset
//   start_i, busy_o, done_o                 transform control
//   din_valid_i, din_ready_o                input sample handshake
//   ld_wr_en_o, ld_wr_addr_o                sample RAM load write
//   rd_en_o, rd_addr_a_o, rd_addr_b_o       sample RAM reads (butterfly and unload)
//   tw_idx_o, bf_valid_o, stage_o           butterfly issue, aligned with read data
//   wr_en_o, wr_addr_a_o, wr_addr_b_o       butterfly result writeback
//   dout_valid_o, dout_last_o               result stream on RAM port A read data
module fft_ctrl #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  input  logic       din_valid_i,
  output logic       din_ready_o,
  output logic       ld_wr_en_o,
  output logic [5:0] ld_wr_addr_o,
  output logic       rd_en_o,
  output logic [5:0] rd_addr_a_o,
  output logic [5:0] rd_addr_b_o,
  output logic [4:0] tw_idx_o,
  output logic       bf_valid_o,
  output logic       wr_en_o,
  output logic [5:0] wr_addr_a_o,
  output logic [5:0] wr_addr_b_o,
  output logic [2:0] stage_o,
  output logic       dout_valid_o,
  output logic       dout_last_o
);

  localparam int D = RD_LAT + BF_LAT;
  localparam logic [2:0] D_LAST = (D > 0) ? 3'(D - 1) : 3'd0;
  localparam logic [6:0] U_LAST = 7'(63 + RD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_UNLOAD, S_DONE} state_t;

  state_t     state;
  logic [5:0] n;
  logic [4:0] k;
  logic [2:0] s;
  logic [2:0] dcnt;
  logic [6:0] ucnt;

  // Butterfly address generation: insert a zero bit at position s of k to get
  // the upper wing, lower wing is span above it.
  logic [5:0] k_ext, span, mask, calc_a, calc_b;
  logic [4:0] calc_tw;
  assign k_ext   = {1'b0, k};
  assign span    = 6'd1 << s;
  assign mask    = span - 6'd1;
  assign calc_a  = ((k_ext >> s) << (s + 3'd1)) | (k_ext & mask);
  assign calc_b  = calc_a + span;
  assign calc_tw = 5'((k_ext & mask) << (3'd5 - s));

  logic calc_rd, unl_rd;
  assign calc_rd = (state == S_CALC);
  assign unl_rd  = (state == S_UNLOAD) && !ucnt[6];

  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign din_ready_o = (state == S_LOAD);
  assign ld_wr_en_o  = din_valid_i & din_ready_o;
  assign stage_o     = s;
  assign rd_en_o     = calc_rd | unl_rd;
  assign rd_addr_a_o = calc_rd ? calc_a : (unl_rd ? ucnt[5:0] : 6'd0);
  assign rd_addr_b_o = calc_rd ? calc_b : 6'd0;

`ifdef FFT_CTRL_BITREV_LOAD_EN
  assign ld_wr_addr_o = {n[0], n[1], n[2], n[3], n[4], n[5]};
`else
  assign ld_wr_addr_o = n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      n     <= '0;
      k     <= '0;
      s     <= '0;
      dcnt  <= '0;
      ucnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state <= S_LOAD;
            n     <= '0;
          end
        end
        S_LOAD: begin
          if (ld_wr_en_o) begin
            n <= n + 6'd1;
            if (n == 6'd63) begin
              k     <= '0;
              s     <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          k <= k + 5'd1;  // wraps to 0 after 31, ready for the next stage
          if (k == 5'd31) begin
            dcnt <= '0;
            if (D != 0) begin
              state <= S_DRAIN;
            end else if (s != 3'd5) begin
              s <= s + 3'd1;
            end else begin
              state <= S_UNLOAD;
              ucnt  <= '0;
            end
          end
        end
        S_DRAIN: begin
          // Holds off the next stage until the last writeback of this one lands.
          dcnt <= dcnt + 3'd1;
          if (dcnt == D_LAST) begin
            if (s != 3'd5) begin
              s     <= s + 3'd1;
              k     <= '0;
              state <= S_CALC;
            end else begin
              state <= S_UNLOAD;
              ucnt  <= '0;
            end
          end
        end
        S_UNLOAD: begin
          // ucnt 0..63 issues reads, then RD_LAT more cycles flush read data.
          ucnt <= ucnt + 7'd1;
          if (ucnt == U_LAST) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay line, entry i holds what was issued i cycles ago. The bf/ul tags keep
  // unload reads from being mistaken for butterfly operations downstream.
  logic       pipe_bf   [1:D];
  logic       pipe_ul   [1:D];
  logic       pipe_last [1:D];
  logic [4:0] pipe_tw   [1:D];
  logic [5:0] pipe_a    [1:D];
  logic [5:0] pipe_b    [1:D];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= D; i++) begin
        pipe_bf[i]   <= 1'b0;
        pipe_ul[i]   <= 1'b0;
        pipe_last[i] <= 1'b0;
        pipe_tw[i]   <= '0;
        pipe_a[i]    <= '0;
        pipe_b[i]    <= '0;
      end
    end else begin
      pipe_bf[1]   <= calc_rd;
      pipe_ul[1]   <= unl_rd;
      pipe_last[1] <= unl_rd && (ucnt[5:0] == 6'd63);
      pipe_tw[1]   <= calc_rd ? calc_tw : 5'd0;
      pipe_a[1]    <= calc_rd ? calc_a : 6'd0;
      pipe_b[1]    <= calc_rd ? calc_b : 6'd0;
      for (int i = 2; i <= D; i++) begin
        pipe_bf[i]   <= pipe_bf[i-1];
        pipe_ul[i]   <= pipe_ul[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_tw[i]   <= pipe_tw[i-1];
        pipe_a[i]    <= pipe_a[i-1];
        pipe_b[i]    <= pipe_b[i-1];
      end
    end
  end

  assign bf_valid_o   = pipe_bf[RD_LAT];
  assign tw_idx_o     = pipe_tw[RD_LAT];
  assign dout_valid_o = pipe_ul[RD_LAT];
  assign dout_last_o  = pipe_last[RD_LAT];
  assign wr_en_o      = pipe_bf[D];
  assign wr_addr_a_o  = pipe_a[D];
  assign wr_addr_b_o  = pipe_b[D];

endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - directed self-checking bench for fft_ctrl (default and RD_LAT=2/BF_LAT=1 instances)
module tb_fft_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_i, din_valid_i;

  logic       busy, done, din_ready, ld_wr_en, rd_en, bf_valid, wr_en, dout_valid, dout_last;
  logic [5:0] ld_wr_addr, rd_a, rd_b, wr_a, wr_b;
  logic [4:0] tw;
  logic [2:0] stage;

  logic       busy2, done2, din_ready2, ld_wr_en2, rd_en2, bf_valid2, wr_en2, dout_valid2, dout_last2;
  logic [5:0] ld_wr_addr2, rd_a2, rd_b2, wr_a2, wr_b2;
  logic [4:0] tw2;
  logic [2:0] stage2;

  fft_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy), .done_o(done),
    .din_valid_i(din_valid_i), .din_ready_o(din_ready), .ld_wr_en_o(ld_wr_en),
    .ld_wr_addr_o(ld_wr_addr), .rd_en_o(rd_en), .rd_addr_a_o(rd_a), .rd_addr_b_o(rd_b),
    .tw_idx_o(tw), .bf_valid_o(bf_valid), .wr_en_o(wr_en), .wr_addr_a_o(wr_a),
    .wr_addr_b_o(wr_b), .stage_o(stage), .dout_valid_o(dout_valid), .dout_last_o(dout_last)
  );

  fft_ctrl #(.RD_LAT(2), .BF_LAT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy2), .done_o(done2),
    .din_valid_i(din_valid_i), .din_ready_o(din_ready2), .ld_wr_en_o(ld_wr_en2),
    .ld_wr_addr_o(ld_wr_addr2), .rd_en_o(rd_en2), .rd_addr_a_o(rd_a2), .rd_addr_b_o(rd_b2),
    .tw_idx_o(tw2), .bf_valid_o(bf_valid2), .wr_en_o(wr_en2), .wr_addr_a_o(wr_a2),
    .wr_addr_b_o(wr_b2), .stage_o(stage2), .dout_valid_o(dout_valid2), .dout_last_o(dout_last2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] exp_addr(input int idx);
    logic [5:0] r;
    r = '0;
`ifdef FFT_CTRL_BITREV_LOAD_EN
    for (int i = 0; i < 6; i++) r[5-i] = idx[i];
`else
    r = idx[5:0];
`endif
    return r;
  endfunction

  int c_unl1, c_unl2, c_done1, c_done2, c_dv1, c_dv2, c_lastwr1, c_lastwr2;
  int nbf1, nbf2, nwr1, nwr2, nd1, nd2, nl1, nl2, lat1, lat2, ndone1, ndone2;
  int nd3, c_done3;
  logic [3:0] pat;

  initial begin
    rst_n = 1'b0; start_i = 1'b1; din_valid_i = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_ready", din_ready, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_a", rd_a, 0);
    check("rst_rd_b", rd_b, 0);
    check("rst_stage", stage, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_bf_tw_dout", {bf_valid, tw, dout_valid, dout_last, wr_a, wr_b, ld_wr_addr}, 0);

    rst_n = 1'b1; start_i = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("load_busy", busy, 1);
    check("load_ready", din_ready, 1);

    // Gapped load: valid pattern 1,0,1,1
    pat = 4'b1101;
    begin
      int nn;
      nn = 0;
      for (int i = 0; i < 4; i++) begin
        din_valid_i = pat[i];
        #1;
        check($sformatf("ld_en_%0d", i), ld_wr_en, pat[i]);
        if (pat[i]) begin
          check($sformatf("ld_addr_%0d", nn), ld_wr_addr, exp_addr(nn));
          nn++;
        end
        tick();
      end
    end
    din_valid_i = 1'b1;
    for (int nn = 3; nn < 63; nn++) begin
      check($sformatf("ld_addr_%0d", nn), ld_wr_addr, exp_addr(nn));
      tick();
    end
    din_valid_i = 1'b0;
    tick();
    check("load_hold_63", din_ready, 1);
    check("load_hold_rd", rd_en, 0);
    check("ld_addr_63", ld_wr_addr, 63);
    din_valid_i = 1'b1;
    tick();
    din_valid_i = 1'b0;

    // CALC entry is cycle 0 for both instances
    c_unl1 = -1; c_unl2 = -1; c_done1 = -1; c_done2 = -1; c_dv1 = -1; c_dv2 = -1;
    c_lastwr1 = -1; c_lastwr2 = -1; nbf1 = 0; nbf2 = 0; nwr1 = 0; nwr2 = 0;
    nd1 = 0; nd2 = 0; nl1 = 0; nl2 = 0; lat1 = 0; lat2 = 0; ndone1 = 0; ndone2 = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (cyc)
        0: begin
          check("s0k0_rd_en", rd_en, 1);
          check("s0k0_ab", {rd_a, rd_b}, {6'd0, 6'd1});
          check("s0k0_stage", stage, 0);
        end
        1: begin
          check("s0k1_ab", {rd_a, rd_b}, {6'd2, 6'd3});
          check("s0k0_bf_tw", {bf_valid, tw}, {1'b1, 5'd0});
          check("s0k0_wr", {wr_en, wr_a, wr_b}, {1'b1, 6'd0, 6'd1});
        end
        2: begin
          check("s0k2_ab", {rd_a, rd_b}, {6'd4, 6'd5});
          check("s0k1_wr", {wr_a, wr_b}, {6'd2, 6'd3});
        end
        32: begin
          check("drain0_rd_en", rd_en, 0);
          check("drain0_wr", {wr_en, wr_a, wr_b}, {1'b1, 6'd62, 6'd63});
        end
        33: check("s1k0", {stage, rd_a, rd_b}, {3'd1, 6'd0, 6'd2});
        50: start_i = 1'b1;
        51: start_i = 1'b0;
        60: check("s1k27_after_start", {busy, stage, rd_a}, {1'b1, 3'd1, 6'd53});
        71: check("s2k5", {stage, rd_a, rd_b}, {3'd2, 6'd9, 6'd13});
        72: check("s2k5_tw", {bf_valid, tw}, {1'b1, 5'd8});
        168: check("s5k3", {stage, rd_a, rd_b}, {3'd5, 6'd3, 6'd35});
        169: check("s5k3_tw", {bf_valid, tw}, {1'b1, 5'd3});
        261: check("unl_a63", {rd_en, rd_a}, {1'b1, 6'd63});
        262: check("unl_end", rd_en, 0);
        default: ;
      endcase

      if (c_unl1 < 0 && rd_en && rd_b == 6'd0) c_unl1 = cyc;
      if (c_unl2 < 0 && rd_en2 && rd_b2 == 6'd0) c_unl2 = cyc;
      if (bf_valid) nbf1++;
      if (bf_valid2) nbf2++;
      if (wr_en) begin nwr1++; c_lastwr1 = cyc; end
      if (wr_en2) begin nwr2++; c_lastwr2 = cyc; end
      if (dout_valid) begin
        if (c_dv1 < 0) c_dv1 = cyc;
        nd1++;
        if (dout_last) begin nl1++; lat1 = nd1; end
      end
      if (dout_valid2) begin
        if (c_dv2 < 0) c_dv2 = cyc;
        nd2++;
        if (dout_last2) begin nl2++; lat2 = nd2; end
      end
      if (done) begin ndone1++; if (c_done1 < 0) c_done1 = cyc; end
      if (done2) begin ndone2++; if (c_done2 < 0) c_done2 = cyc; end
      if (c_done1 >= 0 && c_done2 >= 0 && cyc > c_done2 + 2) break;
      tick();
    end

    check("calc_cycles_d1", c_unl1, 198);
    check("calc_cycles_d3", c_unl2, 210);
    check("bf_count_d1", nbf1, 192);
    check("wr_count_d1", nwr1, 192);
    check("bf_count_d3", nbf2, 192);
    check("wr_count_d3", nwr2, 192);
    check("last_wr_d1", c_lastwr1, 197);
    check("last_wr_d3", c_lastwr2, 209);
    check("first_dout_d1", c_dv1, 199);
    check("first_dout_d3", c_dv2, 212);
    check("dout_count_d1", nd1, 64);
    check("dout_count_d3", nd2, 64);
    check("last_count_d1", nl1, 1);
    check("last_pos_d1", lat1, 64);
    check("last_count_d3", nl2, 1);
    check("last_pos_d3", lat2, 64);
    check("done_pulses_d1", ndone1, 1);
    check("done_pulses_d3", ndone2, 1);
    check("done_cycle_d1", c_done1, 263);
    check("done_cycle_d3", c_done2, 276);

    // Restart straight from IDLE, then reset in stage 3 at k=10
    check("idle_after_done", busy, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("restart_busy", busy, 1);
    din_valid_i = 1'b1;
    repeat (173) tick();
    check("s3k10", {stage, rd_a, rd_b}, {3'd3, 6'd18, 6'd26});
    check("din_ignored_calc", ld_wr_en, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_stage", stage, 0);
    check("midrst_rd", {rd_en, rd_a, rd_b}, 0);
    check("midrst_pipe", {bf_valid, tw, wr_en, wr_a, wr_b, dout_valid, dout_last}, 0);
    check("midrst_misc", {done, din_ready, ld_wr_addr}, 0);

    // Fresh run, continuous input: done 327 cycles after LOAD entry
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    nd3 = 0; c_done3 = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (dout_valid) nd3++;
      if (done) begin c_done3 = cyc; break; end
      tick();
    end
    din_valid_i = 1'b0;
    check("fresh_done_cycle", c_done3, 327);
    check("fresh_dout_count", nd3, 64);
    tick();
    check("fresh_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
